// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard control: load-use stalls, branch flushes, EX forwarding selects and a
// scoreboard of in-flight multi-cycle results, plus a saturating stall-cycle counter.
`ifndef NO_FW
`define NO_FW  2'b00
`endif
`ifndef FW_WB
`define FW_WB  2'b01
`endif
`ifndef FW_MEM
`define FW_MEM 2'b10
`endif

module hazard_scoreboard_unit #(
  parameter int NREGS    = 32,
  parameter int MC_SLOTS = 2,
  parameter int MC_LAT   = 4,
  parameter int CNT_W    = 32,
  localparam int RW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RW-1:0]    rs1_decode,
  input  logic [RW-1:0]    rs2_decode,
  input  logic [RW-1:0]    rd_decode,
  input  logic             reg_write_decode,
  input  logic             mc_op_decode,
  input  logic [RW-1:0]    rs1_execute,
  input  logic [RW-1:0]    rs2_execute,
  input  logic [RW-1:0]    rd_execute,
  input  logic             mem_read_execute,
  input  logic [RW-1:0]    rd_mem,
  input  logic [RW-1:0]    rd_writeback,
  input  logic             reg_write_mem,
  input  logic             reg_write_writeback,
  input  logic             taken_branch,
  output logic [1:0]       forward_rs1_execute,
  output logic [1:0]       forward_rs2_execute,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             flush_decode,
  output logic             flush_execute,
  output logic             sb_full,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [RW-1:0]    REG_ZERO = {RW{1'b0}};
  localparam logic [3:0]       LAT_INIT = 4'(MC_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [MC_SLOTS-1:0] valid_r;
  logic [RW-1:0]       slot_rd_r  [MC_SLOTS];
  logic [3:0]          slot_cnt_r [MC_SLOTS];
  logic [CNT_W-1:0]    stall_count_r;

  logic                load_use_s;
  logic                sb_raw_s;
  logic                sb_waw_s;
  logic                sb_struct_s;
  logic                sb_full_s;
  logic                stall_s;
  logic                alloc_s;
  logic                free_found_s;
  logic [MC_SLOTS-1:0] alloc_oh_s;

  // MEM beats WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] rs,
                                         input logic [RW-1:0] rd_m,
                                         input logic [RW-1:0] rd_w,
                                         input logic          we_m,
                                         input logic          we_w);
    logic [1:0] sel;
    if (rs == REG_ZERO) begin
      sel = `NO_FW;
    end else if (we_m && (rd_m == rs)) begin
      sel = `FW_MEM;
    end else if (we_w && (rd_w == rs)) begin
      sel = `FW_WB;
    end else begin
      sel = `NO_FW;
    end
    return sel;
  endfunction

  assign forward_rs1_execute = fwd_sel(rs1_execute, rd_mem, rd_writeback,
                                       reg_write_mem, reg_write_writeback);
  assign forward_rs2_execute = fwd_sel(rs2_execute, rd_mem, rd_writeback,
                                       reg_write_mem, reg_write_writeback);

  assign sb_full_s = &valid_r;

  // Hazard detection against execute and registered scoreboard state only
  always_comb begin
    load_use_s = mem_read_execute && (rd_execute != REG_ZERO) &&
                 (((rs1_decode != REG_ZERO) && (rs1_decode == rd_execute)) ||
                  ((rs2_decode != REG_ZERO) && (rs2_decode == rd_execute)));
    sb_raw_s = 1'b0;
    sb_waw_s = 1'b0;
    for (int i = 0; i < MC_SLOTS; i++) begin
      sb_raw_s = sb_raw_s | (valid_r[i] &&
                 (((rs1_decode != REG_ZERO) && (slot_rd_r[i] == rs1_decode)) ||
                  ((rs2_decode != REG_ZERO) && (slot_rd_r[i] == rs2_decode))));
      sb_waw_s = sb_waw_s | (valid_r[i] && reg_write_decode &&
                 (rd_decode != REG_ZERO) && (slot_rd_r[i] == rd_decode));
    end
    sb_struct_s = mc_op_decode && sb_full_s;
    stall_s     = load_use_s || sb_raw_s || sb_waw_s || sb_struct_s;
  end

  // Pick the lowest-index free slot for a new multi-cycle op
  always_comb begin
    alloc_s      = mc_op_decode && reg_write_decode && (rd_decode != REG_ZERO) &&
                   !stall_s && !taken_branch;
    alloc_oh_s   = {MC_SLOTS{1'b0}};
    free_found_s = 1'b0;
    for (int i = 0; i < MC_SLOTS; i++) begin
      if (!valid_r[i] && !free_found_s) begin
        alloc_oh_s[i] = alloc_s;
        free_found_s  = 1'b1;
      end else begin
        free_found_s  = free_found_s;
      end
    end
  end

  // Slot countdown; a slot still counting down cannot be reallocated this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MC_SLOTS; i++) begin
        valid_r[i]    <= 1'b0;
        slot_rd_r[i]  <= REG_ZERO;
        slot_cnt_r[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < MC_SLOTS; i++) begin
        if (valid_r[i]) begin
          if (slot_cnt_r[i] == 4'd1) begin
            valid_r[i]    <= 1'b0;
            slot_cnt_r[i] <= 4'd0;
          end else begin
            slot_cnt_r[i] <= slot_cnt_r[i] - 4'd1;
          end
        end else if (alloc_oh_s[i]) begin
          valid_r[i]    <= 1'b1;
          slot_rd_r[i]  <= rd_decode;
          slot_cnt_r[i] <= LAT_INIT;
        end
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end
  end

  assign stall_fetch   = stall_s;
  assign stall_decode  = stall_s;
  assign flush_execute = stall_s | taken_branch;
  assign flush_decode  = taken_branch;
  assign sb_full       = sb_full_s;
  assign stall_count   = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit; expectations are queued by the
// stimulus process and popped/compared by an independent monitor.
module tb_hazard_scoreboard_unit;

  localparam int RW = 5;
  localparam logic [1:0] FW_NO  = 2'b00;
  localparam logic [1:0] FW_MEM = 2'b10;
  localparam logic [1:0] FW_WB  = 2'b01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] rs1_decode, rs2_decode, rd_decode;
  logic          reg_write_decode, mc_op_decode;
  logic [RW-1:0] rs1_execute, rs2_execute, rd_execute;
  logic          mem_read_execute;
  logic [RW-1:0] rd_mem, rd_writeback;
  logic          reg_write_mem, reg_write_writeback, taken_branch;
  logic [1:0]    forward_rs1_execute, forward_rs2_execute;
  logic          stall_fetch, stall_decode, flush_decode, flush_execute, sb_full;
  logic [31:0]   stall_count;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
    .reg_write_decode(reg_write_decode), .mc_op_decode(mc_op_decode),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
    .mem_read_execute(mem_read_execute),
    .rd_mem(rd_mem), .rd_writeback(rd_writeback),
    .reg_write_mem(reg_write_mem), .reg_write_writeback(reg_write_writeback),
    .taken_branch(taken_branch),
    .forward_rs1_execute(forward_rs1_execute), .forward_rs2_execute(forward_rs2_execute),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_decode(flush_decode), .flush_execute(flush_execute),
    .sb_full(sb_full), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  tag;
    logic [1:0]  fw1;
    logic [1:0]  fw2;
    logic        stall;
    logic        fd;
    logic        fe;
    logic        full;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  task automatic cmp(input int tag, input string what, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL tag=%0d %s actual=%0h expected=%0h", tag, what, act, req);
    end
  endtask

  task automatic idle();
    rs1_decode = '0; rs2_decode = '0; rd_decode = '0;
    reg_write_decode = 1'b0; mc_op_decode = 1'b0;
    rs1_execute = '0; rs2_execute = '0; rd_execute = '0; mem_read_execute = 1'b0;
    rd_mem = '0; rd_writeback = '0; reg_write_mem = 1'b0; reg_write_writeback = 1'b0;
    taken_branch = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push_exp(input int tag, input logic [1:0] f1, input logic [1:0] f2,
                          input logic st, input logic fd, input logic fe, input logic full);
    exp_t e;
    e.tag = 8'(tag); e.fw1 = f1; e.fw2 = f2; e.stall = st;
    e.fd = fd; e.fe = fe; e.full = full; e.cnt = 32'(exp_cnt);
    exp_q.push_back(e);
    -> chk_ev;
    if (st) exp_cnt++;
  endtask

  task automatic mc(input logic [RW-1:0] rd);
    mc_op_decode = 1'b1; reg_write_decode = 1'b1; rd_decode = rd;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL queue_underflow actual=empty expected=entry");
      end else begin
        e = exp_q.pop_front();
        cmp(int'(e.tag), "fw_rs1", 32'(forward_rs1_execute), 32'(e.fw1));
        cmp(int'(e.tag), "fw_rs2", 32'(forward_rs2_execute), 32'(e.fw2));
        cmp(int'(e.tag), "stall_fetch", 32'(stall_fetch), 32'(e.stall));
        cmp(int'(e.tag), "stall_decode", 32'(stall_decode), 32'(e.stall));
        cmp(int'(e.tag), "flush_decode", 32'(flush_decode), 32'(e.fd));
        cmp(int'(e.tag), "flush_execute", 32'(flush_execute), 32'(e.fe));
        cmp(int'(e.tag), "sb_full", 32'(sb_full), 32'(e.full));
        cmp(int'(e.tag), "stall_count", stall_count, e.cnt);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #3 push_exp(1, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    #9 rst_n = 1'b1;

    // load-use, then the rd_execute==0 boundary
    tick(); mem_read_execute = 1'b1; rd_execute = 5'd5; rs2_decode = 5'd5;
    push_exp(2, FW_NO, FW_NO, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); push_exp(3, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); mem_read_execute = 1'b1; rd_execute = 5'd0; rs2_decode = 5'd0;
    push_exp(4, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);

    // forwarding priority
    tick(); rs1_execute = 5'd7; rs2_execute = 5'd7; rd_mem = 5'd7; rd_writeback = 5'd7;
    reg_write_mem = 1'b1; reg_write_writeback = 1'b1;
    push_exp(5, FW_MEM, FW_MEM, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); rs1_execute = 5'd0; rs2_execute = 5'd7; rd_mem = 5'd7; rd_writeback = 5'd7;
    reg_write_mem = 1'b0; reg_write_writeback = 1'b1;
    push_exp(6, FW_NO, FW_WB, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); rs1_execute = 5'd3; rs2_execute = 5'd3; rd_mem = 5'd3; rd_writeback = 5'd3;
    push_exp(7, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); rs1_execute = 5'd4; rs2_execute = 5'd5; rd_mem = 5'd5; rd_writeback = 5'd4;
    reg_write_mem = 1'b1; reg_write_writeback = 1'b1;
    push_exp(8, FW_WB, FW_MEM, 1'b0, 1'b0, 1'b0, 1'b0);

    // multi-cycle RAW: stall exactly MC_LAT cycles after allocation
    tick(); mc(5'd9); push_exp(9, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(); rs1_decode = 5'd9; push_exp(10 + k, FW_NO, FW_NO, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    tick(); rs1_decode = 5'd9; push_exp(14, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);

    // structural full, then allocation into the freed slot 0
    tick(); mc(5'd3); push_exp(15, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); mc(5'd4); push_exp(16, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(); mc(5'd6); push_exp(17 + k, FW_NO, FW_NO, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    tick(); mc(5'd6); push_exp(20, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); rs1_decode = 5'd6; push_exp(21, FW_NO, FW_NO, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); rs1_decode = 5'd4; push_exp(22, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); reg_write_decode = 1'b1; rd_decode = 5'd6;
    push_exp(23, FW_NO, FW_NO, 1'b1, 1'b0, 1'b1, 1'b0);

    // taken branch blocks allocation; existing slot keeps counting
    tick(); taken_branch = 1'b1; mc(5'd12);
    push_exp(24, FW_NO, FW_NO, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); rs1_decode = 5'd12; rs2_decode = 5'd6;
    push_exp(25, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);

    // async reset with both slots valid
    tick(); mc(5'd20); push_exp(26, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); mc(5'd21); push_exp(27, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); push_exp(28, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b1);
    #3; rs1_decode = 5'd20; mc_op_decode = 1'b1; rst_n = 1'b0;
    #1; exp_cnt = 0; push_exp(29, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);
    #2; rst_n = 1'b1;
    tick(); rs1_decode = 5'd20; push_exp(30, FW_NO, FW_NO, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation pipeline hazard unit for the RV64 core: load-use stalls, branch flushes and EX operand forwarding, plus a scoreboard of in-flight multi-cycle operations (MUL/DIV).
- Stalls decode on RAW/WAW hazards against pending multi-cycle results and on scoreboard-full.
- Keeps a saturating stall-cycle counter for performance monitoring.
- Sits beside the five-stage pipeline, driving stall/flush to fetch, decode and execute, and forward selects to the EX operand muxes.

Parameters:
- NREGS, 32, architectural register count; RW = $clog2(NREGS) is the index width.
- MC_SLOTS, 2, max in-flight multi-cycle ops (1..8).
- MC_LAT, 4, cycles from multi-cycle allocation to result written at writeback (2..15).
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rs1_decode, rs2_decode  in  RW  source regs in decode
- rd_decode  in  RW  destination in decode
- reg_write_decode  in  1  decode instr writes rd
- mc_op_decode  in  1  decode instr is multi-cycle
- rs1_execute, rs2_execute  in  RW  source regs in execute
- rd_execute  in  RW  destination in execute
- mem_read_execute  in  1  execute instr is a load
- rd_mem, rd_writeback  in  RW  destinations in mem/wb
- reg_write_mem, reg_write_writeback  in  1  write enables in mem/wb
- taken_branch  in  1  branch/jump resolved taken in execute
- forward_rs1_execute, forward_rs2_execute  out  2  `NO_FW / `FW_MEM / `FW_WB (defines.sv)
- stall_fetch, stall_decode  out  1  hold PC / IF-ID register
- flush_decode, flush_execute  out  1  bubble IF-ID / ID-EX register
- sb_full  out  1  all slots valid
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0):
  - all slots invalid, counters 0, stall_count=0, sb_full=0.
  - Comb outputs follow the rules below with an empty scoreboard.
- Slot state: valid bit, rd[RW], cnt[4].
- Forwarding (combinational), per operand:
  - operand index 0 -> `NO_FW;
  - else reg_write_mem & rd_mem match -> `FW_MEM (MEM has priority);
  - else reg_write_writeback & rd_writeback match -> `FW_WB;
  - else `NO_FW.
- Stall sources (combinational; each term below requires the compared decode operand to be nonzero):
  - load_use: mem_read_execute & rd_execute!=0 & (rs1_decode==rd_execute | rs2_decode==rd_execute).
  - sb_raw: any valid slot with rd equal to rs1_decode or rs2_decode.
  - sb_waw: reg_write_decode & any valid slot with rd==rd_decode.
  - sb_struct: mc_op_decode & sb_full.
- Comparison rule: the scoreboard compares against registered state only; a slot freeing this cycle still counts (conservative).
- Outputs:
  - stall = OR of the four stall sources.
  - stall_fetch = stall_decode = stall.
  - flush_execute = stall | taken_branch.
  - flush_decode = taken_branch.
- Allocation:
  - Condition: mc_op_decode & reg_write_decode & rd_decode!=0 & !stall & !taken_branch.
  - Allocates the lowest-index invalid slot at the clock edge: valid=1, rd=rd_decode, cnt=MC_LAT.
- Countdown:
  - Each valid slot decrements cnt every cycle.
  - A slot with cnt==1 becomes invalid next edge.
  - A slot is therefore valid for exactly MC_LAT cycles after allocation.
  - Allocation into a slot freeing the same edge is not allowed (it is not yet invalid), so there is no same-slot conflict.
- Flush: taken_branch never kills valid slots (they are older than the branch); it only blocks allocation.
- sb_full is registered-state derived: AND of valid bits.
- stall_count increments by 1 on each edge where stall=1; saturates at all-ones; no wrap.
- Reset mid-operation clears all slots immediately and asynchronously; pending results are dropped.

Test Plan:
- Load-use: mem_read_execute=1, rd_execute=5, rs2_decode=5 -> stall_fetch=stall_decode=flush_execute=1 for one cycle; stall_count 0->1. Same with rd_execute=0 -> no stall.
- Forward priority: rs1_execute=7, rd_mem=7, rd_writeback=7, both write enables 1 -> forward_rs1_execute=`FW_MEM. rs1_execute=0 -> `NO_FW.
- MC RAW: allocate mc op rd=9, MC_LAT=4; next cycle rs1_decode=9 -> stall asserted for exactly 4 cycles after allocation edge, deasserted on the 5th.
- Structural full: MC_SLOTS=2, allocate rd=3, rd=4 on consecutive cycles; third mc op -> sb_full=1, stall until slot 0 frees, then allocates into slot 0.
- Branch: taken_branch=1 with mc_op_decode=1 -> flush_decode=flush_execute=1, no allocation; existing slots keep counting.
- Async reset with 2 slots valid and stall_count=10 -> sb_full=0, stall_count=0, no sb stall immediately, without a clock edge.
